regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (wrenable/address/data into the 32x32 register array) between two writeback requesters.
- Requester A is the ALU writeback; requester B is the load/memory writeback.
- Uses fixed priority to B, with a starvation counter that guarantees A progress.
- Output is registered: one write per cycle, 1-cycle latency from acceptance to the register-file write strobe.

Parameters:
WIDTH, 32, data width of a register-file entry
ADDR_W, 5, register address width (2**ADDR_W registers)
STARVE_LIMIT, 4, consecutive cycles A may be refused before A gets priority; legal range 1..15

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
a_valid  input  1  A has a write pending
a_ready  output  1  A write accepted this cycle (combinational)
a_addr  input  ADDR_W  A destination register
a_data  input  WIDTH  A write data
b_valid  input  1  B has a write pending
b_ready  output  1  B write accepted this cycle (combinational)
b_addr  input  ADDR_W  B destination register
b_data  input  WIDTH  B write data
rf_wrenable  output  1  write strobe to register file (registered)
rf_wraddr  output  ADDR_W  register-file write address (registered)
rf_wrdata  output  WIDTH  register-file write data (registered)
a_prio  output  1  high while the arbiter is in A_PRI state (debug/perf visibility)

Behaviour:
- Clocking and reset: one clock, clk. reset_n is asynchronous, active-low.
  - While reset_n=0: rf_wrenable=0, rf_wraddr=0, rf_wrdata=0, state=B_PRI, a_prio=0, starve_cnt=0.
  - a_ready and b_ready are 0 while reset_n=0.
  - Writes accepted but not yet strobed are discarded on reset mid-operation.
- Handshake:
  - A transfer occurs on a rising edge where valid&&ready.
  - The requester holds valid, addr and data stable until accepted. valid must not depend on ready.
  - At most one of a_ready/b_ready is high per cycle.
  - ready is never high without the matching valid.
- States:
  - B_PRI (reset state):
    - b_ready=b_valid.
    - a_ready=a_valid&&!b_valid.
  - A_PRI:
    - a_ready=a_valid.
    - b_ready=b_valid&&!a_valid.
- starve_cnt (4 bits):
  - In B_PRI, increments when a_valid&&!a_ready.
  - Clears to 0 on any cycle where a_valid=0 or A is accepted.
- Transitions:
  - B_PRI->A_PRI at the edge where starve_cnt would reach STARVE_LIMIT.
  - A_PRI->B_PRI at the edge where A is accepted, or where a_valid=0 (A withdrew; legal only after reset). starve_cnt=0 on that exit.
- a_prio = (state==A_PRI).
- Write path, per cycle:
  - If a transfer is accepted in cycle N, then in cycle N+1: rf_wraddr=winner addr, rf_wrdata=winner data, rf_wrenable=1.
  - Exception: register 0 is hardwired zero. A transfer with addr==0 is accepted (ready asserted normally), but rf_wrenable stays 0 in N+1. rf_wraddr/rf_wrdata still update.
  - If no transfer in cycle N: rf_wrenable=0 in N+1; rf_wraddr/rf_wrdata hold their previous values.
- Throughput: back-to-back transfers every cycle, no bubbles.
- Same-address collision (a_addr==b_addr, both valid):
  - The winner is written in cycle N+1 and the loser in a later cycle.
  - The later write is the final register value. Ordering between A and B is the pipeline's responsibility, not the arbiter's.
- Worst-case A latency under continuous b_valid: STARVE_LIMIT+1 cycles from a_valid to acceptance.

Test Plan:
1. Reset: assert reset_n=0 mid-stream with a_valid=b_valid=1 -> all outputs 0 immediately (asynchronous). After release, the first accepted write is B's, and rf_wrenable=1 one cycle later.
2. Single requester: A alone writes addr=7, data=0xDEADBEEF -> a_ready=1 in the same cycle. Next cycle rf_wrenable=1, rf_wraddr=7, rf_wrdata=0xDEADBEEF.
3. Zero register: B writes addr=0, data=0x12345678 -> b_ready=1, and rf_wrenable stays 0 the next cycle.
4. Starvation, STARVE_LIMIT=4: b_valid held high and a_valid high from cycle 0 -> B accepted in cycles 0-3, a_prio=1 from cycle 4, A accepted in cycle 4. Then B_PRI resumes and B is accepted in cycle 5.
5. Back-to-back: alternate A/B transfers for 8 consecutive cycles to addresses 1..8 -> rf_wrenable high for 8 consecutive cycles with matching addr/data in order, and never both readies high.
6. Collision: A and B both target addr=3 (A=0x1, B=0x2) in B_PRI -> cycle N+1 writes 0x2, cycle N+2 writes 0x1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between ALU (A) and load (B) writeback, B-priority with A starvation guard
module regfile_write_arbiter #(
   parameter int WIDTH        = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [WIDTH-1:0]  a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [WIDTH-1:0]  b_data,
   output logic              rf_wrenable,
   output logic [ADDR_W-1:0] rf_wraddr,
   output logic [WIDTH-1:0]  rf_wrdata,
   output logic              a_prio
);
   typedef enum logic {B_PRI, A_PRI} state_t;
   state_t            state, state_nx;
   logic [3:0]        starve_cnt, starve_nx;
   logic              xfer;
   logic [ADDR_W-1:0] w_addr;
   logic [WIDTH-1:0]  w_data;
   always_comb begin
      a_ready   = reset_n && a_valid && (state == A_PRI || !b_valid);
      b_ready   = reset_n && b_valid && !(state == A_PRI && a_valid);
      starve_nx = (!a_valid || a_ready) ? 4'd0 : (state == B_PRI) ? starve_cnt + 4'd1 : starve_cnt;
      state_nx  = (state == A_PRI) ? ((a_ready || !a_valid) ? B_PRI : A_PRI)
                : (starve_nx == 4'(STARVE_LIMIT)) ? A_PRI : B_PRI;
      xfer      = a_ready || b_ready;
      w_addr    = a_ready ? a_addr : b_addr;
      w_data    = a_ready ? a_data : b_data;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= B_PRI;
         starve_cnt  <= '0;
         rf_wrenable <= 1'b0;
         rf_wraddr   <= '0;
         rf_wrdata   <= '0;
      end else begin
         state       <= state_nx;
         starve_cnt  <= starve_nx;
         rf_wrenable <= xfer && (w_addr != '0);
         if (xfer) begin
            rf_wraddr <= w_addr;
            rf_wrdata <= w_data;
         end
      end
   end
   assign a_prio = (state == A_PRI);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed stimulus checked against a behavioural arbitration model every cycle
module tb_regfile_write_arbiter;
   localparam int W = 32, AW = 5, LIM = 4;
   logic          clk = 0, reset_n = 0;
   logic          a_valid = 0, b_valid = 0, a_ready, b_ready;
   logic [AW-1:0] a_addr = 0, b_addr = 0, rf_wraddr;
   logic [W-1:0]  a_data = 0, b_data = 0, rf_wrdata;
   logic          rf_wrenable, a_prio;
   int            checks = 0, errors = 0;
   int            a_wait;
   logic          exp_wen;
   logic [AW-1:0] exp_addr;
   logic [W-1:0]  exp_data;

   regfile_write_arbiter #(.WIDTH(W), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .rf_wrenable(rf_wrenable), .rf_wraddr(rf_wraddr), .rf_wrdata(rf_wrdata), .a_prio(a_prio));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // A gets priority once it has been refused LIM consecutive cycles
   function automatic logic m_a_acc();
      return reset_n && a_valid && (a_wait >= LIM || !b_valid);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_wait = 0; exp_wen = 0; exp_addr = 0; exp_data = 0;
      end else begin
         logic aa, ba;
         aa = m_a_acc();
         ba = b_valid && !aa;
         exp_wen = (aa || ba) && ((aa ? a_addr : b_addr) != 0);
         if (aa || ba) begin
            exp_addr = aa ? a_addr : b_addr;
            exp_data = aa ? a_data : b_data;
         end
         a_wait = (!a_valid || aa) ? 0 : a_wait + 1;
      end
   end

   always @(negedge clk) begin
      chk("m_a_ready", a_ready, m_a_acc());
      chk("m_b_ready", b_ready, reset_n && b_valid && !m_a_acc());
      chk("m_a_prio", a_prio, a_wait >= LIM);
      chk("m_wen", rf_wrenable, exp_wen);
      chk("m_waddr", rf_wraddr, exp_addr);
      chk("m_wdata", rf_wrdata, exp_data);
      chk("excl", a_ready && b_ready, 0);
   end

   task automatic cyc(input logic av, input logic [AW-1:0] aad, input logic [W-1:0] ad,
                      input logic bv, input logic [AW-1:0] bad, input logic [W-1:0] bd);
      @(posedge clk); #1;
      a_valid = av; a_addr = aad; a_data = ad;
      b_valid = bv; b_addr = bad; b_data = bd;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #23 reset_n = 1;
      idle();
      chk("rst_wen", rf_wrenable, 0);
      chk("rst_prio", a_prio, 0);
      // single A write
      cyc(1, 7, 32'hDEADBEEF, 0, 0, 0);
      chk("a_alone_rdy", a_ready, 1);
      idle();
      chk("a_alone_wen", rf_wrenable, 1);
      chk("a_alone_addr", rf_wraddr, 7);
      chk("a_alone_data", rf_wrdata, 32'hDEADBEEF);
      // zero register write is accepted but not strobed
      cyc(0, 0, 0, 1, 0, 32'h12345678);
      chk("zero_rdy", b_ready, 1);
      idle();
      chk("zero_wen", rf_wrenable, 0);
      chk("zero_data", rf_wrdata, 32'h12345678);
      idle();
      // starvation: B wins cycles 0-3, A at 4, B again at 5
      for (int k = 0; k < 6; k++) begin
         cyc(1, (k < 5) ? 5'd9 : 5'd11, (k < 5) ? 32'hA9 : 32'hAB, 1, 5'(10 + k), 32'hB0 + k);
         chk("starve_b_rdy", b_ready, k != 4);
         chk("starve_a_rdy", a_ready, k == 4);
         chk("starve_prio", a_prio, k == 4);
      end
      idle();
      chk("starve_last_addr", rf_wraddr, 15);
      idle();
      // back-to-back alternating A/B to addresses 1..8
      for (int i = 1; i <= 8; i++) begin
         if (i % 2) cyc(1, 5'(i), 32'h100 + i, 0, 0, 0);
         else       cyc(0, 0, 0, 1, 5'(i), 32'h200 + i);
         if (i > 1) begin
            chk("b2b_wen", rf_wrenable, 1);
            chk("b2b_addr", rf_wraddr, i - 1);
         end
      end
      idle();
      chk("b2b_wen_last", rf_wrenable, 1);
      chk("b2b_data_last", rf_wrdata, 32'h208);
      idle();
      // collision on register 3: B first, then A
      cyc(1, 3, 32'h1, 1, 3, 32'h2);
      chk("col_b_first", b_ready, 1);
      cyc(1, 3, 32'h1, 0, 0, 0);
      chk("col_n1_data", rf_wrdata, 32'h2);
      chk("col_a_second", a_ready, 1);
      idle();
      chk("col_n2_data", rf_wrdata, 32'h1);
      chk("col_n2_wen", rf_wrenable, 1);
      // asynchronous reset in the middle of a stream
      cyc(1, 4, 32'h44, 1, 6, 32'h66);
      cyc(1, 4, 32'h44, 1, 6, 32'h67);
      @(posedge clk); #2 reset_n = 0; #1;
      chk("arst_wen", rf_wrenable, 0);
      chk("arst_addr", rf_wraddr, 0);
      chk("arst_data", rf_wrdata, 0);
      chk("arst_ardy", a_ready, 0);
      chk("arst_brdy", b_ready, 0);
      chk("arst_prio", a_prio, 0);
      @(negedge clk);
      @(posedge clk); #1 reset_n = 1;
      @(negedge clk);
      chk("post_rst_b", b_ready, 1);
      chk("post_rst_a", a_ready, 0);
      idle();
      chk("post_rst_wen", rf_wrenable, 1);
      chk("post_rst_addr", rf_wraddr, 6);
      idle();
      idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
